// File: rtl/mem_wb_elastic_reg.sv
// -----------------------------------------------------------------------------
// mem_wb_elastic_reg
//
// Elastic MEM/WB pipeline register. The memory-stage payload moves through
// STAGES slots, from slot 0 (input) to slot STAGES-1 (head). Each slot has its
// own valid bit. Ready/valid handshakes on both sides replace the old global
// freeze. Writeback sees the head slot directly.
//
// Optional feature: define MEM_WB_FWD_EN to add the fwd_valid/fwd_wsel/fwd_data
// outputs. These forward the youngest buffered register write.
//
// Parameters
//   WORD_W    data word width
//   REGSEL_W  register select width
//   STAGES    buffered slots (1..4); accept-to-wb_valid latency in cycles
//
// Ports
//   CLK, RST        clock, synchronous active-high reset
//   flush           drop every buffered entry (and any same-cycle accept)
//   mem_valid/ready upstream handshake; mem* payload inputs
//   wb_valid/ready  downstream handshake; wb* payload outputs from head slot
//   wbwdat          resolved writeback data of the head slot
//   wb_commit       head consumed and written (suppressed by flush)
//   halt_seen       sticky, a halt entry has committed
//   fwd_*           (MEM_WB_FWD_EN only) youngest pending register write
// -----------------------------------------------------------------------------
module mem_wb_elastic_reg #(
  parameter int WORD_W   = 32,
  parameter int REGSEL_W = 5,
  parameter int STAGES   = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                flush,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic                memMemToReg,
  input  logic                memWEN,
  input  logic                memLUIflag,
  input  logic                memHALT,
  input  logic [REGSEL_W-1:0] memwsel,
  input  logic [WORD_W-1:0]   memOutput_Port,
  input  logic [WORD_W-1:0]   memdmemload,
  input  logic [WORD_W-1:0]   meminstr,
  input  logic [WORD_W-1:0]   memLUIdata,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic                wbMemToReg,
  output logic                wbWEN,
  output logic                wbLUIflag,
  output logic [REGSEL_W-1:0] wbwsel,
  output logic [WORD_W-1:0]   wbOutput_Port,
  output logic [WORD_W-1:0]   wbdmemload,
  output logic [WORD_W-1:0]   wbinstr,
  output logic [WORD_W-1:0]   wbLUIdata,
  output logic [WORD_W-1:0]   wbwdat,
  output logic                wb_commit,
  output logic                halt_seen
`ifdef MEM_WB_FWD_EN
  ,
  output logic                fwd_valid,
  output logic [REGSEL_W-1:0] fwd_wsel,
  output logic [WORD_W-1:0]   fwd_data
`endif
);

  // Packed slot payload: {MemToReg, WEN, LUIflag, HALT, wsel, Output_Port,
  // dmemload, instr, LUIdata}
  localparam int LUI_LSB   = 0;
  localparam int INSTR_LSB = WORD_W;
  localparam int DMEM_LSB  = 2 * WORD_W;
  localparam int OUT_LSB   = 3 * WORD_W;
  localparam int WSEL_LSB  = 4 * WORD_W;
  localparam int HALT_BIT  = WSEL_LSB + REGSEL_W;
  localparam int LUIF_BIT  = HALT_BIT + 1;
  localparam int WEN_BIT   = HALT_BIT + 2;
  localparam int M2R_BIT   = HALT_BIT + 3;
  localparam int PL_W      = M2R_BIT + 1;
  localparam int HEAD      = STAGES - 1;

  logic [PL_W-1:0]   r_slot [STAGES];
  logic [STAGES-1:0] r_valid;
  logic              r_halt_pending;
  logic              r_halt_seen;

  logic [PL_W-1:0]   w_in;
  logic [PL_W-1:0]   w_src [STAGES];
  logic [STAGES-1:0] w_adv;
  logic [STAGES-1:0] w_load;
  logic              w_accept;
  logic [PL_W-1:0]   w_head;

  // Writeback data selection shared by wbwdat and the forwarding path.
  function automatic logic [WORD_W-1:0] f_wdat(input logic [PL_W-1:0] p);
    if (p[M2R_BIT])
      return p[DMEM_LSB +: WORD_W];
    else if (p[LUIF_BIT])
      return p[LUI_LSB +: WORD_W];
    else
      return p[OUT_LSB +: WORD_W];
  endfunction

  assign w_in = {memMemToReg, memWEN, memLUIflag, memHALT, memwsel,
                 memOutput_Port, memdmemload, meminstr, memLUIdata};

  // A slot leaves when its successor is empty or leaving in the same cycle.
  // This is evaluated from the head backwards, so the ready chain stays free
  // of any mem_valid dependence.
  always_comb begin
    w_adv       = '0;
    w_adv[HEAD] = r_valid[HEAD] & wb_ready;
    for (int i = STAGES - 2; i >= 0; i--) begin
      w_adv[i] = r_valid[i] & (~r_valid[i+1] | w_adv[i+1]);
    end
  end

  assign mem_ready = ~r_halt_pending & (~r_valid[0] | w_adv[0]);
  assign w_accept  = mem_valid & mem_ready;

  // Each slot loads from the slot before it (slot 0 from the input).
  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_slot_src
      if (gi == 0) begin : g_first
        assign w_src[gi]  = w_in;
        assign w_load[gi] = w_accept & ~flush;
      end else begin : g_chain
        assign w_src[gi]  = r_slot[gi-1];
        assign w_load[gi] = w_adv[gi-1] & ~flush;
      end
    end
  endgenerate

  always_ff @(posedge CLK) begin
    for (int i = 0; i < STAGES; i++) begin
      if (RST) begin
        r_valid[i] <= 1'b0;
        r_slot[i]  <= '0;
      end else if (flush) begin
        r_valid[i] <= 1'b0;
      end else if (w_load[i]) begin
        // A load takes priority over an emptying advance, so a slot that
        // passes its entry on and takes a new one in the same cycle stays valid.
        r_valid[i] <= 1'b1;
        r_slot[i]  <= w_src[i];
      end else if (w_adv[i]) begin
        r_valid[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_halt_pending <= 1'b0;
    end else if (flush) begin
      r_halt_pending <= 1'b0;
    end else if (w_accept && memHALT) begin
      r_halt_pending <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_halt_seen <= 1'b0;
    end else if (wb_commit && w_head[HALT_BIT]) begin
      r_halt_seen <= 1'b1;
    end
  end

  assign w_head        = r_slot[HEAD];
  assign wb_valid      = r_valid[HEAD];
  assign wbMemToReg    = w_head[M2R_BIT];
  assign wbLUIflag     = w_head[LUIF_BIT];
  // Never signal a write to r0.
  assign wbWEN         = w_head[WEN_BIT] & (|w_head[WSEL_LSB +: REGSEL_W]);
  assign wbwsel        = w_head[WSEL_LSB +: REGSEL_W];
  assign wbOutput_Port = w_head[OUT_LSB +: WORD_W];
  assign wbdmemload    = w_head[DMEM_LSB +: WORD_W];
  assign wbinstr       = w_head[INSTR_LSB +: WORD_W];
  assign wbLUIdata     = w_head[LUI_LSB +: WORD_W];
  assign wbwdat        = f_wdat(w_head);
  // A flushed head is dropped rather than written.
  assign wb_commit     = w_adv[HEAD] & ~flush;
  assign halt_seen     = r_halt_seen;

`ifdef MEM_WB_FWD_EN
  // Scan oldest to youngest so the youngest qualifying slot wins.
  always_comb begin
    fwd_valid = 1'b0;
    fwd_wsel  = '0;
    fwd_data  = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (r_valid[i] && r_slot[i][WEN_BIT] && (|r_slot[i][WSEL_LSB +: REGSEL_W])) begin
        fwd_valid = 1'b1;
        fwd_wsel  = r_slot[i][WSEL_LSB +: REGSEL_W];
        fwd_data  = f_wdat(r_slot[i]);
      end
    end
    if (flush) begin
      fwd_valid = 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_elastic_reg.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_elastic_reg
//
// Directed bench driving two instances from the same inputs: u_dut1
// (STAGES=1) and u_dut2 (STAGES=2). Expected values are hand-computed
// constants. With MEM_WB_FWD_EN defined, the bench also checks the forwarding
// outputs of u_dut2.
// -----------------------------------------------------------------------------
module tb_mem_wb_elastic_reg;

  logic        clk = 1'b0;
  logic        RST, flush, mem_valid, wb_ready;
  logic        memMemToReg, memWEN, memLUIflag, memHALT;
  logic [4:0]  memwsel;
  logic [31:0] memOutput_Port, memdmemload, meminstr, memLUIdata;

  logic        mem_ready_1, wb_valid_1, wbMemToReg_1, wbWEN_1, wbLUIflag_1;
  logic        wb_commit_1, halt_seen_1;
  logic [4:0]  wbwsel_1;
  logic [31:0] wbOutput_Port_1, wbdmemload_1, wbinstr_1, wbLUIdata_1, wbwdat_1;

  logic        mem_ready_2, wb_valid_2, wbMemToReg_2, wbWEN_2, wbLUIflag_2;
  logic        wb_commit_2, halt_seen_2;
  logic [4:0]  wbwsel_2;
  logic [31:0] wbOutput_Port_2, wbdmemload_2, wbinstr_2, wbLUIdata_2, wbwdat_2;

`ifdef MEM_WB_FWD_EN
  logic        fwd_valid_1, fwd_valid_2;
  logic [4:0]  fwd_wsel_1, fwd_wsel_2;
  logic [31:0] fwd_data_1, fwd_data_2;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_wb_elastic_reg #(.WORD_W(32), .REGSEL_W(5), .STAGES(1)) u_dut1 (
    .CLK(clk), .RST(RST), .flush(flush), .mem_valid(mem_valid), .mem_ready(mem_ready_1),
    .memMemToReg(memMemToReg), .memWEN(memWEN), .memLUIflag(memLUIflag), .memHALT(memHALT),
    .memwsel(memwsel), .memOutput_Port(memOutput_Port), .memdmemload(memdmemload),
    .meminstr(meminstr), .memLUIdata(memLUIdata),
    .wb_valid(wb_valid_1), .wb_ready(wb_ready),
    .wbMemToReg(wbMemToReg_1), .wbWEN(wbWEN_1), .wbLUIflag(wbLUIflag_1), .wbwsel(wbwsel_1),
    .wbOutput_Port(wbOutput_Port_1), .wbdmemload(wbdmemload_1), .wbinstr(wbinstr_1),
    .wbLUIdata(wbLUIdata_1), .wbwdat(wbwdat_1), .wb_commit(wb_commit_1), .halt_seen(halt_seen_1)
`ifdef MEM_WB_FWD_EN
    , .fwd_valid(fwd_valid_1), .fwd_wsel(fwd_wsel_1), .fwd_data(fwd_data_1)
`endif
  );

  mem_wb_elastic_reg #(.WORD_W(32), .REGSEL_W(5), .STAGES(2)) u_dut2 (
    .CLK(clk), .RST(RST), .flush(flush), .mem_valid(mem_valid), .mem_ready(mem_ready_2),
    .memMemToReg(memMemToReg), .memWEN(memWEN), .memLUIflag(memLUIflag), .memHALT(memHALT),
    .memwsel(memwsel), .memOutput_Port(memOutput_Port), .memdmemload(memdmemload),
    .meminstr(meminstr), .memLUIdata(memLUIdata),
    .wb_valid(wb_valid_2), .wb_ready(wb_ready),
    .wbMemToReg(wbMemToReg_2), .wbWEN(wbWEN_2), .wbLUIflag(wbLUIflag_2), .wbwsel(wbwsel_2),
    .wbOutput_Port(wbOutput_Port_2), .wbdmemload(wbdmemload_2), .wbinstr(wbinstr_2),
    .wbLUIdata(wbLUIdata_2), .wbwdat(wbwdat_2), .wb_commit(wb_commit_2), .halt_seen(halt_seen_2)
`ifdef MEM_WB_FWD_EN
    , .fwd_valid(fwd_valid_2), .fwd_wsel(fwd_wsel_2), .fwd_data(fwd_data_2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] wsel, input logic [31:0] outp,
                       input logic [31:0] dmem, input logic [31:0] lui, input logic m2r,
                       input logic luif, input logic wen, input logic halt);
    mem_valid      = v;
    memwsel        = wsel;
    memOutput_Port = outp;
    memdmemload    = dmem;
    meminstr       = outp + 32'd1;
    memLUIdata     = lui;
    memMemToReg    = m2r;
    memLUIflag     = luif;
    memWEN         = wen;
    memHALT        = halt;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    RST      = 1'b1;
    flush    = 1'b0;
    wb_ready = 1'b0;
    idle();
    tick();
    tick();
    RST = 1'b0;
    #1;
  endtask

  logic [31:0] stream_vals [4] = '{32'h10, 32'h20, 32'h30, 32'h40};

  initial begin
    // Reset state
    do_reset();
    check("rst1_wb_valid",  {31'd0, wb_valid_1}, 32'd0);
    check("rst1_halt_seen", {31'd0, halt_seen_1}, 32'd0);
    check("rst1_wbwdat",    wbwdat_1, 32'd0);
    check("rst1_mem_ready", {31'd0, mem_ready_1}, 32'd1);
    check("rst2_wb_valid",  {31'd0, wb_valid_2}, 32'd0);
    check("rst2_wbWEN",     {31'd0, wbWEN_2}, 32'd0);
    check("rst2_mem_ready", {31'd0, mem_ready_2}, 32'd1);

    // Back-to-back streaming through STAGES=2
    wb_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        drive(1'b1, 5'd3, stream_vals[k], 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        check($sformatf("strm_mem_ready_%0d", k), {31'd0, mem_ready_2}, 32'd1);
      end else begin
        idle();
      end
      tick();
      if (k >= 1 && k <= 4) begin
        check($sformatf("strm_wb_valid_%0d", k), {31'd0, wb_valid_2}, 32'd1);
        check($sformatf("strm_wbwdat_%0d", k), wbwdat_2, stream_vals[k-1]);
        check($sformatf("strm_commit_%0d", k), {31'd0, wb_commit_2}, 32'd1);
      end
      if (k == 1) begin
        check("strm_wbWEN", {31'd0, wbWEN_2}, 32'd1);
        check("strm_wbinstr", wbinstr_2, 32'h11);
      end
      if (k == 5) check("strm_drained", {31'd0, wb_valid_2}, 32'd0);
    end

    // Back-pressure on STAGES=2
    do_reset();
    drive(1'b1, 5'd7, 32'hA1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    check("bp_ready_a", {31'd0, mem_ready_2}, 32'd1);
    tick();
    drive(1'b1, 5'd7, 32'hB2, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    check("bp_ready_b", {31'd0, mem_ready_2}, 32'd1);
    tick();
    drive(1'b1, 5'd7, 32'hC3, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    check("bp_ready_c_full", {31'd0, mem_ready_2}, 32'd0);
    tick();
    check("bp_hold_head", wbwdat_2, 32'hA1);
    wb_ready = 1'b1;
    #1;
    check("bp_ready_c_drain", {31'd0, mem_ready_2}, 32'd1);
    tick();
    idle();
    check("bp_out_b", wbwdat_2, 32'hB2);
    tick();
    check("bp_out_c", wbwdat_2, 32'hC3);
    check("bp_out_c_valid", {31'd0, wb_valid_2}, 32'd1);
    tick();
    check("bp_empty", {31'd0, wb_valid_2}, 32'd0);

    // Writeback data selection and r0 suppression
    do_reset();
    wb_ready = 1'b1;
    drive(1'b1, 5'd4, 32'h1, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd6, 32'h2, 32'h0, 32'hABCD0000, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    check("sel_m2r", wbwdat_2, 32'hDEADBEEF);
    check("sel_m2r_wen", {31'd0, wbWEN_2}, 32'd1);
    drive(1'b1, 5'd0, 32'h3, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    check("sel_lui", wbwdat_2, 32'hABCD0000);
    tick();
    check("sel_r0_valid", {31'd0, wb_valid_2}, 32'd1);
    check("sel_r0_wen", {31'd0, wbWEN_2}, 32'd0);
    check("sel_alu", wbwdat_2, 32'h3);

    // Halt, then flush
    do_reset();
    drive(1'b1, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    check("halt_ready_pre", {31'd0, mem_ready_2}, 32'd1);
    tick();
    idle();
    wb_ready = 1'b1;
    #1;
    check("halt_ready_blocked", {31'd0, mem_ready_2}, 32'd0);
    tick();
    check("halt_head_valid", {31'd0, wb_valid_2}, 32'd1);
    check("halt_commit", {31'd0, wb_commit_2}, 32'd1);
    check("halt_seen_pre", {31'd0, halt_seen_2}, 32'd0);
    tick();
    check("halt_seen_set", {31'd0, halt_seen_2}, 32'd1);
    drive(1'b1, 5'd9, 32'h99, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    check("halt_ready_still0", {31'd0, mem_ready_2}, 32'd0);
    tick();
    idle();
    tick();
    check("halt_no_accept", {31'd0, wb_valid_2}, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("flush_clears_pending", {31'd0, mem_ready_2}, 32'd1);
    wb_ready = 1'b0;
    drive(1'b1, 5'd2, 32'hE1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd2, 32'hE2, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    check("flush_head_valid", {31'd0, wb_valid_2}, 32'd1);
    flush    = 1'b1;
    wb_ready = 1'b1;
    #1;
    check("flush_commit_blocked", {31'd0, wb_commit_2}, 32'd0);
    tick();
    flush = 1'b0;
    #1;
    check("flush_wb_valid", {31'd0, wb_valid_2}, 32'd0);
    check("flush_halt_seen_kept", {31'd0, halt_seen_2}, 32'd1);
    tick();
    check("flush_all_dropped", {31'd0, wb_valid_2}, 32'd0);

    // STAGES=1: commit and accept in the same cycle
    do_reset();
    wb_ready = 1'b1;
    drive(1'b1, 5'd1, 32'h71, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check("s1_head_x", wbwdat_1, 32'h71);
    drive(1'b1, 5'd1, 32'h72, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    check("s1_ready_full_commit", {31'd0, mem_ready_1}, 32'd1);
    tick();
    idle();
    check("s1_reload_valid", {31'd0, wb_valid_1}, 32'd1);
    check("s1_head_y", wbwdat_1, 32'h72);
    tick();
    check("s1_empty", {31'd0, wb_valid_1}, 32'd0);

`ifdef MEM_WB_FWD_EN
    // Forwarding picks the youngest qualifying slot
    do_reset();
    drive(1'b1, 5'd5, 32'h11, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd5, 32'h55, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    check("fwd_valid", {31'd0, fwd_valid_2}, 32'd1);
    check("fwd_wsel", {27'd0, fwd_wsel_2}, 32'd5);
    check("fwd_data", fwd_data_2, 32'h55);
    flush = 1'b1;
    #1;
    check("fwd_flush", {31'd0, fwd_valid_2}, 32'd0);
    tick();
    flush = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_elastic_reg.md
Name: mem_wb_elastic_reg

Overview:
- Parametrised MEM/WB pipeline register, successor to the fixed single-slot MEM/WB latch.
- Holds STAGES slots of MEM→WB payload with per-slot valid bits.
- Uses a ready/valid handshake on both sides, so memory stalls and writeback back-pressure no longer need a global freeze.
- Adds flush, a sticky halt, and writeback-select (wsel=0) suppression.
- Sits between the memory stage and register-file writeback.

Parameters:
WORD_W, 32, width of data words (output port, dmemload, instr, luidata)
REGSEL_W, 5, width of register write-select
STAGES, 1, number of buffered slots (legal 1..4); latency in cycles from accept to out_valid

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  synchronous active-high reset
flush  in  1  drop all buffered entries this cycle
mem_valid  in  1  upstream entry valid
mem_ready  out  1  this block can accept an entry this cycle
memMemToReg  in  1  select dmemload as writeback data
memWEN  in  1  register write enable
memLUIflag  in  1  select LUI data as writeback data
memHALT  in  1  entry is a halt
memwsel  in  REGSEL_W  destination register
memOutput_Port  in  WORD_W  ALU result
memdmemload  in  WORD_W  load data
meminstr  in  WORD_W  instruction word
memLUIdata  in  WORD_W  upper-immediate data
wb_valid  out  1  head entry valid
wb_ready  in  1  writeback consumes head entry
wbMemToReg, wbWEN, wbLUIflag  out  1 each  head entry control
wbwsel  out  REGSEL_W  head destination
wbOutput_Port, wbdmemload, wbinstr, wbLUIdata  out  WORD_W each  head payload
wbwdat  out  WORD_W  resolved writeback data
wb_commit  out  1  wb_valid & wb_ready
halt_seen  out  1  sticky: a halt entry has committed

Behaviour:
- Slots form a shift chain from slot 0 (input) to slot STAGES-1 (head).
- A slot advances when the next slot is empty or is being emptied in the same cycle.
- The head empties on wb_commit.
- mem_ready = !halt_pending & (slot0 empty | slot0 advancing). The ready chain is combinational; there is no combinational path from mem_valid to mem_ready.
- Accept = mem_valid & mem_ready. The payload is captured into slot 0 and its valid bit is set.
- Latency:
  - An entry accepted in cycle N shows wb_valid in cycle N+STAGES if there is no back-pressure.
  - Full throughput is 1 entry/cycle when wb_ready is held high.
- wb_* outputs are registered directly from the head slot. When wb_valid=0, payload outputs hold their last values and are don't-care.
- wbwdat is combinational from the head slot:
  - memToReg → dmemload
  - else LUIflag → LUIdata
  - else Output_Port
- wbWEN output = head WEN & (wsel != 0). A write to r0 is never signalled.
- Halt:
  - halt_pending sets when a halt entry is accepted. While it is set, mem_ready=0 and no further entries are accepted.
  - halt_seen sets on the commit of a halt entry and stays high until RST.
- flush:
  - Clears all valid bits and halt_pending next cycle.
  - An accept in the same cycle is discarded.
  - A commit in the same cycle still completes, but wb_commit is forced 0 if flush=1, so the head is dropped rather than written.
  - flush does not clear halt_seen.
- Simultaneous commit at a full head and accept into slot 0 at STAGES=1: both occur; the slot is reloaded with the new entry and stays valid.
- Reset values:
  - All valid bits, halt_pending, halt_seen, wb_valid, mem_ready-internal state = 0.
  - All payload registers = 0.
  - Consequently wbwdat=0 and all wb_* outputs = 0.
- RST mid-operation discards all entries regardless of the handshake. RST overrides flush.

Optional Feature:
MEM_WB_FWD_EN:
- When defined, the block adds outputs fwd_valid (1), fwd_wsel (REGSEL_W) and fwd_data (WORD_W).
- These reflect the youngest valid slot with WEN=1 and wsel≠0, where slot 0 is youngest.
- fwd_data is that slot's resolved writeback data, using the same mux as wbwdat.
- fwd_valid=0 if no slot qualifies; it also resets to 0 and is forced 0 during flush.
- When undefined, these ports and their logic do not exist, and behaviour is otherwise identical.

Test Plan:
- RST high 2 cycles, STAGES=1 → wb_valid=0, halt_seen=0, wbwdat=0, mem_ready=1 the cycle after RST drops.
- Back-to-back streaming: STAGES=2, wb_ready=1, accept 4 entries (Output_Port=0x10,0x20,0x30,0x40, WEN=1, wsel=3) in consecutive cycles → wb_valid from cycle 2, one commit per cycle, wbwdat=0x10..0x40 in order.
- Back-pressure: STAGES=2, wb_ready=0, offer 3 entries → only 2 accepted, mem_ready=0 on the 3rd. Raise wb_ready → entries drain in order with no loss or duplication.
- Writeback select: entries with MemToReg=1 (dmemload=0xDEADBEEF), LUIflag=1 (LUIdata=0xABCD0000), and wsel=0 with WEN=1 → wbwdat=0xDEADBEEF, then 0xABCD0000, then wbWEN=0.
- Halt then flush: accept a halt entry → mem_ready=0. On commit, halt_seen=1 and stays 1. Assert flush with 2 entries buffered (wb_ready=1) → wb_commit=0 that cycle, wb_valid=0 next cycle, halt_seen remains 1.
- MEM_WB_FWD_EN, STAGES=2: slot0 wsel=5 data=0x55, slot1 wsel=5 data=0x11 → fwd_wsel=5, fwd_data=0x55.
